dbus_wishbone_if: RTL and testbench
===================================

Name: dbus_wishbone_if

Overview:
- Data-side bus bridge between the OpenMIPS MEM stage and a Wishbone B3 classic master port.
- Consumes the MEM-stage load/store request (address, write data, byte select, write enable, chip enable).
- Runs one Wishbone single-beat cycle per request. Raises stallreq to the pipeline controller until the access completes.
- Holds read data while the pipeline remains stalled, and aborts cleanly on flush (exception).

Parameters:
- STALL_IDX, 4, bit of stall_i that freezes the consumer stage (the MEM stage).
- TIMEOUT_CYC, 255, cycles without ack before abort. Used only with the optional feature; legal range 1..255, 8-bit counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cpu_ce_i  in  1  MEM-stage access request
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address
- cpu_data_i  in  32  store data
- cpu_sel_i  in  4  byte lanes
- cpu_data_o  out  32  load data to MEM stage
- stall_i  in  6  pipeline stall vector from ctrl
- flush_i  in  1  pipeline flush
- stallreq_o  out  1  stall request to ctrl
- wb_ack_i  in  1  Wishbone ack
- wb_data_i  in  32  Wishbone read data
- wb_addr_o  out  32  Wishbone address
- wb_data_o  out  32  Wishbone write data
- wb_we_o  out  1  Wishbone write enable
- wb_sel_o  out  4  Wishbone byte select
- wb_stb_o  out  1  Wishbone strobe
- wb_cyc_o  out  1  Wishbone cycle
- bus_err_o  out  1  timeout abort pulse

Behaviour:
- Reset, asynchronous on rst_n=0:
  - State IDLE.
  - wb_addr_o, wb_data_o and rd_buf = 0.
  - wb_sel_o = 4'b0000.
  - wb_we_o, wb_stb_o, wb_cyc_o and bus_err_o = 0.
  - Timeout counter = 0.
- Registered outputs: all wb_* outputs, bus_err_o and the internal rd_buf.
- Combinational outputs: stallreq_o and cpu_data_o.
- States are IDLE, BUSY and WAIT_STALL.
- IDLE:
  - If cpu_ce_i=1 and flush_i=0: next edge latches addr, data, we and sel onto wb_*, sets stb=cyc=1, and moves to BUSY.
  - stallreq_o = cpu_ce_i & ~flush_i. cpu_data_o = 0.
- BUSY:
  - If flush_i=1: next edge drops stb/cyc, clears wb_* and rd_buf, and returns to IDLE. No data is returned. A flush takes priority over a same-cycle ack.
  - Else if wb_ack_i=1: next edge drops stb/cyc and clears addr/data/sel/we to 0. On a load, rd_buf <= wb_data_i. If stall_i[STALL_IDX]=1 the block moves to WAIT_STALL, else to IDLE.
  - Else it holds.
  - stallreq_o = ~wb_ack_i & ~flush_i.
  - cpu_data_o = wb_data_i when ack and load, else 0. Load data is forwarded in the ack cycle, so a zero-wait-state slave costs 1 stall cycle.
- WAIT_STALL:
  - Entered when the pipeline is still stalled by another requester (e.g. the instruction bus).
  - stallreq_o = 0. cpu_data_o = rd_buf.
  - If flush_i=1, or stall_i[STALL_IDX]=0: next edge goes to IDLE and clears rd_buf.
- Minimum access: request cycle, then BUSY with ack, giving 2 clk from ce to data when ack is immediate.
- Strobe integrity: stb/cyc never deassert in BUSY without ack, flush or timeout.
- No back-to-back stb: at least one idle cycle (stb=0) between Wishbone cycles.
- A request present in IDLE with flush_i=1 is ignored.

Optional Feature:
- Macro: DBUS_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on BUSY entry and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT_CYC-1 with no ack, the next edge aborts: stb/cyc drop, rd_buf = 0, bus_err_o pulses 1 for one cycle, and the state goes to IDLE (or WAIT_STALL per the stall rule).
  - stallreq_o = 0 in the abort cycle, and cpu_data_o = 0.
- Undefined: no counter; BUSY waits indefinitely; bus_err_o is tied 0.

Test Plan:
- Load, immediate ack:
  - Stimulus: ce=1, we=0, addr=0x0000_0010, sel=4'hF; ack the cycle after stb with wb_data_i=0xDEAD_BEEF; stall_i=0.
  - Response: stallreq is high for 2 cycles (request cycle and BUSY); cpu_data_o=0xDEADBEEF in the ack cycle; stb is low the next cycle.
- Store, 3-cycle wait:
  - Stimulus: ce=1, we=1, addr=0x0000_0040, data=0x1234_5678, sel=4'b0011.
  - Response: wb_addr_o, wb_data_o, wb_sel_o and wb_we_o are held stable with stb=cyc=1 for 3 cycles; stallreq stays 1 until the ack cycle, then drops.
- Stall hold:
  - Stimulus: load acked with 0xCAFE_0001 while stall_i[4]=1 for 4 further cycles.
  - Response: state is WAIT_STALL; cpu_data_o=0xCAFE0001 for those 4 cycles; stallreq=0; after stall_i[4]=0 the block is in IDLE with cpu_data_o=0.
- Flush mid-access:
  - Stimulus: flush_i=1 in the second BUSY cycle, coinciding with ack.
  - Response: ack is ignored; stb/cyc drop next edge; cpu_data_o=0; state is IDLE.
- Async reset mid-BUSY:
  - Stimulus: rst_n=0 asserted between edges.
  - Response: stb, cyc, we, sel and addr are 0 immediately; stallreq=0.
- With DBUS_TIMEOUT_EN and TIMEOUT_CYC=8:
  - Stimulus: no ack.
  - Response: stb is high for 8 cycles; bus_err_o pulses once; stallreq releases; cpu_data_o=0.

Source files
------------

// File: rtl/dbus_wishbone_if.sv
// Data-side bridge from the OpenMIPS MEM stage to a Wishbone B3 classic single-beat master.
// Optional ack timeout abort is enabled by defining DBUS_TIMEOUT_EN.
module dbus_wishbone_if #(
  parameter int unsigned STALL_IDX   = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_data_o,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StWaitStall} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_d, wdata_d, rd_buf_q, rd_buf_d;
  logic [3:0]  sel_d;
  logic        we_d, stb_d, cyc_d;
  logic        tmo_hit;
  logic        mem_stalled;

  assign mem_stalled = stall_i[STALL_IDX];

  // Only the consumer stage's stall bit matters here.
  logic unused_stall;
  assign unused_stall = ^stall_i;

`ifdef DBUS_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (state_q == StBusy) && !wb_ack_i && !flush_i &&
                   (tmo_cnt_q == 8'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == StIdle) begin
      tmo_cnt_d = '0;
    end else if (state_q == StBusy && !wb_ack_i) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      bus_err_o <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      bus_err_o <= tmo_hit;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = wb_addr_o;
    wdata_d    = wb_data_o;
    sel_d      = wb_sel_o;
    we_d       = wb_we_o;
    stb_d      = wb_stb_o;
    cyc_d      = wb_cyc_o;
    rd_buf_d   = rd_buf_q;
    stallreq_o = 1'b0;
    cpu_data_o = '0;

    unique case (state_q)
      StIdle: begin
        stallreq_o = cpu_ce_i & ~flush_i;
        if (cpu_ce_i && !flush_i) begin
          addr_d  = cpu_addr_i;
          wdata_d = cpu_data_i;
          sel_d   = cpu_sel_i;
          we_d    = cpu_we_i;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          state_d = StBusy;
        end
      end
      StBusy: begin
        stallreq_o = ~wb_ack_i & ~flush_i & ~tmo_hit;
        if (flush_i || wb_ack_i || tmo_hit) begin
          addr_d  = '0;
          wdata_d = '0;
          sel_d   = '0;
          we_d    = 1'b0;
          stb_d   = 1'b0;
          cyc_d   = 1'b0;
        end
        if (flush_i) begin
          rd_buf_d = '0;
          state_d  = StIdle;
        end else if (wb_ack_i || tmo_hit) begin
          // Stores and timeouts leave a clean zero for a following WAIT_STALL.
          rd_buf_d = (wb_ack_i && !wb_we_o) ? wb_data_i : '0;
          if (wb_ack_i && !wb_we_o) cpu_data_o = wb_data_i;
          state_d = mem_stalled ? StWaitStall : StIdle;
        end
      end
      StWaitStall: begin
        cpu_data_o = rd_buf_q;
        if (flush_i || !mem_stalled) begin
          rd_buf_d = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wb_addr_o <= '0;
      wb_data_o <= '0;
      wb_sel_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
      rd_buf_q  <= '0;
    end else begin
      state_q   <= state_d;
      wb_addr_o <= addr_d;
      wb_data_o <= wdata_d;
      wb_sel_o  <= sel_d;
      wb_we_o   <= we_d;
      wb_stb_o  <= stb_d;
      wb_cyc_o  <= cyc_d;
      rd_buf_q  <= rd_buf_d;
    end
  end

endmodule

// File: tb/tb_dbus_wishbone_if.sv
// Scoreboard bench for dbus_wishbone_if: driver queues expected bus requests and load results,
// an independent monitor pops and compares whenever the DUT presents them.
module tb_dbus_wishbone_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_ce_i, cpu_we_i, flush_i, wb_ack_i;
  logic [31:0] cpu_addr_i, cpu_data_i, wb_data_i;
  logic [3:0]  cpu_sel_i;
  logic [5:0]  stall_i;
  logic [31:0] cpu_data_o, wb_addr_o, wb_data_o;
  logic        stallreq_o, wb_we_o, wb_stb_o, wb_cyc_o, bus_err_o;
  logic [3:0]  wb_sel_o;

  always #5 clk = ~clk;

  dbus_wishbone_if #(.STALL_IDX(4), .TIMEOUT_CYC(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_i (cpu_data_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_data_o (cpu_data_o),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .stallreq_o (stallreq_o),
    .wb_ack_i   (wb_ack_i),
    .wb_data_i  (wb_data_i),
    .wb_addr_o  (wb_addr_o),
    .wb_data_o  (wb_data_o),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .bus_err_o  (bus_err_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        we;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rsp_q[$];
  logic [31:0] hold_q[$];
  req_t        cur;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        chk_en = 1'b0, hold_phase = 1'b0, tmo_phase = 1'b0, cyc_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a load that completes normally returns the slave's word; anything else yields 0.
  function automatic logic [31:0] exp_rdata(input logic we, input logic [31:0] rd, input int mode);
    return (mode != 0 || we) ? 32'h0 : rd;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_cyc_o && !cyc_prev) begin
        if (req_q.size() == 0) begin
          chk("unexpected_cycle", 32'(wb_cyc_o), 32'h0);
        end else begin
          cur = req_q.pop_front();
          chk("req_addr", wb_addr_o, cur.addr);
          chk("req_data", wb_data_o, cur.data);
          chk("req_sel", 32'(wb_sel_o), 32'(cur.sel));
          chk("req_we", 32'(wb_we_o), 32'(cur.we));
          chk("req_bus_err", 32'(bus_err_o), 32'h0);
        end
      end
      if (wb_cyc_o && !tmo_phase) begin
        if (wb_ack_i || flush_i) begin
          if (rsp_q.size() == 0) begin
            chk("rsp_queue_empty", 32'(rsp_q.size()), 32'h1);
          end else begin
            chk("rsp_cpu_data", cpu_data_o, rsp_q.pop_front());
            chk("rsp_stallreq", 32'(stallreq_o), 32'h0);
          end
        end else begin
          chk("busy_stallreq", 32'(stallreq_o), 32'h1);
          chk("busy_cpu_data", cpu_data_o, 32'h0);
          chk("busy_stb", 32'(wb_stb_o), 32'h1);
          chk("busy_addr", wb_addr_o, cur.addr);
          chk("busy_wdata", wb_data_o, cur.data);
          chk("busy_sel", 32'(wb_sel_o), 32'(cur.sel));
          chk("busy_we", 32'(wb_we_o), 32'(cur.we));
        end
      end
      if (hold_phase) begin
        if (hold_q.size() == 0) begin
          chk("hold_queue_empty", 32'(hold_q.size()), 32'h1);
        end else begin
          chk("hold_cpu_data", cpu_data_o, hold_q.pop_front());
          chk("hold_stallreq", 32'(stallreq_o), 32'h0);
          chk("hold_cyc", 32'(wb_cyc_o), 32'h0);
        end
      end
      if (chk_en) begin
        chk("idle_stallreq", 32'(stallreq_o), 32'(cpu_ce_i & ~flush_i));
        chk("idle_cpu_data", cpu_data_o, 32'h0);
        chk("idle_cyc", 32'(wb_cyc_o), 32'h0);
      end
    end
    cyc_prev = wb_cyc_o;
  end

  // mode: 0 normal ack, 1 flush coinciding with ack, 2 flush without ack
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [3:0] sel, input int wait_n,
                        input int hold_n, input int mode);
    logic [31:0] e;
    req_t r;
    e = exp_rdata(we, rdata, mode);
    r.addr = addr; r.data = wdata; r.sel = sel; r.we = we;
    req_q.push_back(r);
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = wdata; cpu_sel_i = sel;
    flush_i = 1'b0; wb_ack_i = 1'b0; stall_i = '0; chk_en = 1'b1;
    step();
    chk_en = 1'b0;
    repeat (wait_n) step();
    if (mode == 2) begin
      flush_i = 1'b1;
    end else begin
      wb_ack_i = 1'b1; wb_data_i = rdata; flush_i = (mode == 1);
    end
    stall_i[4] = (hold_n > 0);
    rsp_q.push_back(e);
    step();
    cpu_ce_i = 1'b0; wb_ack_i = 1'b0; flush_i = 1'b0; wb_data_i = $urandom;
    if (hold_n > 0) begin
      hold_phase = 1'b1;
      for (int i = 0; i < hold_n; i++) begin
        hold_q.push_back(e);
        step();
      end
      hold_phase = 1'b0;
    end
    stall_i = '0;
    step();
    chk_en = 1'b1;
    step();
    chk_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cpu_ce_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_data_i = '0; cpu_sel_i = '0;
    stall_i = '0; flush_i = 0; wb_ack_i = 0; wb_data_i = '0;
    #12;
    chk("rst_addr", wb_addr_o, 32'h0);
    chk("rst_wdata", wb_data_o, 32'h0);
    chk("rst_sel", 32'(wb_sel_o), 32'h0);
    chk("rst_ctl", {28'h0, wb_we_o, wb_stb_o, wb_cyc_o, bus_err_o}, 32'h0);
    chk("rst_stallreq", 32'(stallreq_o), 32'h0);
    chk("rst_cpu_data", cpu_data_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    do_txn(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 4'hF, 1, 0, 0);
    do_txn(1'b1, 32'h0000_0040, 32'h1234_5678, 32'h5555_AAAA, 4'b0011, 2, 0, 0);
    do_txn(1'b0, 32'h0000_0080, 32'h0, 32'hCAFE_0001, 4'hF, 0, 4, 0);
    do_txn(1'b0, 32'h0000_00C0, 32'h0, 32'hBAD0_BAD0, 4'hF, 1, 2, 1);

    // Request with flush in IDLE must be dropped
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h100; flush_i = 1'b1; chk_en = 1'b1;
    step();
    chk_en = 1'b0; cpu_ce_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk("idle_flush_no_cyc", 32'(wb_cyc_o), 32'h0);
    step();

    for (int n = 0; n < 30; n++) begin
      int r;
      int mode;
      r = $urandom_range(0, 9);
      mode = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 4'($urandom),
             $urandom_range(0, 3), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0, mode);
    end

    // Asynchronous reset in the middle of a BUSY cycle
    begin
      req_t r;
      r.addr = 32'h0000_0ABC; r.data = 32'h7777_0000; r.sel = 4'hF; r.we = 1'b1;
      req_q.push_back(r);
      cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = r.addr; cpu_data_i = r.data;
      cpu_sel_i = r.sel;
      step();
      step();
      #2;
      rst_n = 1'b0; cpu_ce_i = 1'b0;
      #1;
      chk("arst_stb_cyc", {30'h0, wb_stb_o, wb_cyc_o}, 32'h0);
      chk("arst_we_sel", {27'h0, wb_we_o, wb_sel_o}, 32'h0);
      chk("arst_addr", wb_addr_o, 32'h0);
      chk("arst_stallreq", 32'(stallreq_o), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
    end

`ifdef DBUS_TIMEOUT_EN
    begin
      req_t r;
      int n_stb, n_err;
      n_stb = 0; n_err = 0;
      r.addr = 32'h0000_0200; r.data = 32'h0; r.sel = 4'hF; r.we = 1'b0;
      req_q.push_back(r);
      tmo_phase = 1'b1;
      cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = r.addr; cpu_sel_i = r.sel;
      step();
      cpu_ce_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (wb_stb_o) n_stb++;
        if (bus_err_o) n_err++;
        if (wb_stb_o && !stallreq_o) chk("tmo_abort_cpu_data", cpu_data_o, 32'h0);
      end
      chk("tmo_stb_cycles", 32'(n_stb), 32'd8);
      chk("tmo_bus_err_pulses", 32'(n_err), 32'd1);
      chk("tmo_stallreq_released", 32'(stallreq_o), 32'h0);
      tmo_phase = 1'b0;
      step();
    end
`endif

    step();
    chk("queues_drained", 32'(req_q.size() + rsp_q.size() + hold_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
